// File: rtl/hazard_forward_unit.sv
// Decode-side dependence checker: tracks in-flight writers after decode, selects
// per-operand forwarding sources, stalls decode on load-use and emits EX/DM memory controls.
module hazard_forward_unit #(
  parameter int unsigned STAGES     = 2,
  parameter int unsigned LOAD_STAGE = 2,
  parameter logic [5:0]  OP_LOAD    = 6'b100011,
  parameter logic [5:0]  OP_STORE   = 6'b101011,
  parameter int unsigned ZERO_REG   = 1,
  parameter int unsigned SW         = $clog2(STAGES + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   ins,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          stall,
  output logic [5:0]    op_dec,
  output logic [15:0]   imm,
  output logic          imm_sel,
  output logic [SW-1:0] mux_sel_A,
  output logic [SW-1:0] mux_sel_B,
  output logic          mem_en_ex,
  output logic          mem_rw_ex,
  output logic          mem_mux_sel_dm,
  output logic [4:0]    RW_dm,
  output logic          wb_en_dm
);

  localparam logic [SW-1:0] FIRST = SW'(1);
  localparam logic [SW-1:0] LAST  = SW'(STAGES);

  logic                  d_valid;
  logic [31:0]           d_ins;
  logic [STAGES:1]       w_valid;
  logic [STAGES:1][5:0]  w_op;
  logic [STAGES:1][4:0]  w_rd;

  logic [5:0]    d_op;
  logic [4:0]    d_rd, d_rs1, d_rs2;
  logic          d_load, d_store, d_imm_sel;
  logic          rs1_live, rs2_live;
  logic          hazard;
  logic [SW-1:0] sel_a, sel_b;

  assign d_op      = d_ins[31:26];
  assign d_rd      = d_ins[25:21];
  assign d_rs1     = d_ins[20:16];
  assign d_rs2     = d_ins[15:11];
  assign d_load    = d_valid && (d_op == OP_LOAD);
  assign d_store   = d_valid && (d_op == OP_STORE);
  assign d_imm_sel = d_valid && (d_op[0] || d_load || d_store);

  // A source is "live" only if it is actually read and not the hardwired zero register.
  assign rs1_live = d_valid && !((ZERO_REG != 0) && (d_rs1 == 5'd0));
  assign rs2_live = d_valid && !d_imm_sel && !((ZERO_REG != 0) && (d_rs2 == 5'd0));

  // Scan oldest to youngest so the youngest matching writer overwrites the select.
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    hazard = 1'b0;
    for (int unsigned k = STAGES; k >= 1; k--) begin
      if (w_valid[SW'(k)] && (w_op[SW'(k)] != OP_STORE)) begin
        if (rs1_live && (w_rd[SW'(k)] == d_rs1)) sel_a = SW'(k);
        if (rs2_live && (w_rd[SW'(k)] == d_rs2)) sel_b = SW'(k);
        if ((k < LAST_LOAD()) && (w_op[SW'(k)] == OP_LOAD) &&
            ((rs1_live && (w_rd[SW'(k)] == d_rs1)) ||
             (rs2_live && (w_rd[SW'(k)] == d_rs2))))
          hazard = 1'b1;
      end
    end
  end

  function automatic int unsigned LAST_LOAD();
    return LOAD_STAGE;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_valid <= 1'b0;
      d_ins   <= '0;
      w_valid <= '0;
      w_op    <= '0;
      w_rd    <= '0;
    end else begin
      for (int unsigned k = 1; k < STAGES; k++) begin
        w_valid[SW'(k + 1)] <= w_valid[SW'(k)];
        w_op[SW'(k + 1)]    <= w_op[SW'(k)];
        w_rd[SW'(k + 1)]    <= w_rd[SW'(k)];
      end
      if (!hazard) begin
        w_valid[FIRST] <= d_valid;
        w_op[FIRST]    <= d_op;
        w_rd[FIRST]    <= d_rd;
        d_valid        <= in_valid;
        d_ins          <= in_valid ? ins : '0;
      end else begin
        // Decode holds; a bubble enters stage 1 while the load moves on.
        w_valid[FIRST] <= 1'b0;
        w_op[FIRST]    <= '0;
        w_rd[FIRST]    <= '0;
      end
    end
  end

  assign in_ready       = !hazard;
  assign stall          = hazard;
  assign op_dec         = d_op;
  assign imm            = d_ins[15:0];
  assign imm_sel        = d_imm_sel;
  assign mux_sel_A      = sel_a;
  assign mux_sel_B      = sel_b;
  assign mem_en_ex      = w_valid[FIRST] && ((w_op[FIRST] == OP_LOAD) || (w_op[FIRST] == OP_STORE));
  assign mem_rw_ex      = w_valid[FIRST] && (w_op[FIRST] == OP_STORE);
  assign mem_mux_sel_dm = w_valid[LAST] && (w_op[LAST] == OP_LOAD);
  assign RW_dm          = w_rd[LAST];
  assign wb_en_dm       = w_valid[LAST] && (w_op[LAST] != OP_STORE);

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench for hazard_forward_unit: directed instruction stream with hand-computed
// decode-stage expectations, plus a 3-stage instance for the long load-use stall.
`timescale 1ns/1ps
module tb_hazard_forward_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ins = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, stall, imm_sel, mem_en_ex, mem_rw_ex, mem_mux_sel_dm, wb_en_dm;
  logic [5:0]  op_dec;
  logic [15:0] imm;
  logic [1:0]  mux_sel_A, mux_sel_B;
  logic [4:0]  RW_dm;

  logic [31:0] ins3 = '0;
  logic        in_valid3 = 1'b0;
  logic        in_ready3, stall3, imm_sel3, mem_en_ex3, mem_rw_ex3, mem_mux_sel_dm3, wb_en_dm3;
  logic [5:0]  op_dec3;
  logic [15:0] imm3;
  logic [1:0]  mux_sel_A3, mux_sel_B3;
  logic [4:0]  RW_dm3;

  always #5 clk = ~clk;

  hazard_forward_unit dut (
    .clk(clk), .reset(reset), .ins(ins), .in_valid(in_valid), .in_ready(in_ready),
    .stall(stall), .op_dec(op_dec), .imm(imm), .imm_sel(imm_sel),
    .mux_sel_A(mux_sel_A), .mux_sel_B(mux_sel_B), .mem_en_ex(mem_en_ex),
    .mem_rw_ex(mem_rw_ex), .mem_mux_sel_dm(mem_mux_sel_dm), .RW_dm(RW_dm),
    .wb_en_dm(wb_en_dm)
  );

  hazard_forward_unit #(.STAGES(3), .LOAD_STAGE(3)) dut3 (
    .clk(clk), .reset(reset), .ins(ins3), .in_valid(in_valid3), .in_ready(in_ready3),
    .stall(stall3), .op_dec(op_dec3), .imm(imm3), .imm_sel(imm_sel3),
    .mux_sel_A(mux_sel_A3), .mux_sel_B(mux_sel_B3), .mem_en_ex(mem_en_ex3),
    .mem_rw_ex(mem_rw_ex3), .mem_mux_sel_dm(mem_mux_sel_dm3), .RW_dm(RW_dm3),
    .wb_en_dm(wb_en_dm3)
  );

  typedef struct {
    int          id;
    logic [5:0]  op;
    logic [15:0] imm;
    logic        isel;
    logic [1:0]  sa, sb;
    logic        men, mrw, mdm;
    logic [4:0]  rw;
    logic        wb;
    int          stalls;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  exp_t none;
  int   n_checks = 0;
  int   n_fail = 0;
  int   stall_cnt = 0;
  bit   occ = 1'b0;
  bit   mon_en = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int id, input logic [5:0] op, input logic [15:0] im,
                              input logic is, input logic [1:0] sa, input logic [1:0] sbv,
                              input logic men, input logic mrw, input logic mdm,
                              input logic [4:0] rw, input logic wb, input int st);
    exp_t e;
    e.id = id; e.op = op; e.imm = im; e.isel = is; e.sa = sa; e.sb = sbv;
    e.men = men; e.mrw = mrw; e.mdm = mdm; e.rw = rw; e.wb = wb; e.stalls = st;
    return e;
  endfunction

  // Decode presents a result when it holds a valid instruction and is not stalled.
  always @(negedge clk) begin
    if (!reset) begin
      occ = 1'b0;
      stall_cnt = 0;
    end else if (mon_en) begin
      if (occ && !in_ready) begin
        stall_cnt++;
      end else if (occ) begin
        check("scoreboard_nonempty", sb_q.size() != 0, 1'b1);
        if (sb_q.size() != 0) begin
          mon_e = sb_q.pop_front();
          check($sformatf("i%0d.op_dec", mon_e.id), op_dec, mon_e.op);
          check($sformatf("i%0d.imm", mon_e.id), imm, mon_e.imm);
          check($sformatf("i%0d.imm_sel", mon_e.id), imm_sel, mon_e.isel);
          check($sformatf("i%0d.mux_sel_A", mon_e.id), mux_sel_A, mon_e.sa);
          check($sformatf("i%0d.mux_sel_B", mon_e.id), mux_sel_B, mon_e.sb);
          check($sformatf("i%0d.mem_en_ex", mon_e.id), mem_en_ex, mon_e.men);
          check($sformatf("i%0d.mem_rw_ex", mon_e.id), mem_rw_ex, mon_e.mrw);
          check($sformatf("i%0d.mem_mux_sel_dm", mon_e.id), mem_mux_sel_dm, mon_e.mdm);
          check($sformatf("i%0d.RW_dm", mon_e.id), RW_dm, mon_e.rw);
          check($sformatf("i%0d.wb_en_dm", mon_e.id), wb_en_dm, mon_e.wb);
          check($sformatf("i%0d.stall_cycles", mon_e.id), stall_cnt, mon_e.stalls);
        end
        stall_cnt = 0;
      end
      if (in_ready) occ = in_valid;
    end
  end

  task automatic send(input logic [31:0] x, input exp_t e, input bit push);
    int n = 0;
    if (push) sb_q.push_back(e);
    @(posedge clk); #1;
    ins = x;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) check("send_timeout", n, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      ins = '0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #2 reset = 1'b0;
    #1;
    check("reset_outputs", {op_dec, imm, imm_sel, mux_sel_A, mux_sel_B, mem_en_ex, mem_rw_ex,
                            mem_mux_sel_dm, RW_dm, wb_en_dm, stall}, 0);
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_in_ready_s3", in_ready3, 1'b1);
    #1 reset = 1'b1;

    //        id  ins           op     imm      is sa sb men mrw mdm rw wb st
    send(32'h0022_1800, mk(1,  6'h00, 16'h1800, 0, 0, 0, 0, 0, 0, 0,  0, 0), 1);
    send(32'h0081_0000, mk(2,  6'h00, 16'h0000, 0, 1, 0, 0, 0, 0, 0,  0, 0), 1);
    send(32'h00A1_2000, mk(3,  6'h00, 16'h2000, 0, 2, 1, 0, 0, 0, 1,  1, 0), 1);
    idle(3);
    send(32'h34C1_0005, mk(4,  6'h0D, 16'h0005, 1, 0, 0, 0, 0, 0, 0,  0, 0), 1);
    send(32'h8CE0_0000, mk(5,  6'h23, 16'h0000, 1, 0, 0, 0, 0, 0, 0,  0, 0), 1);
    send(32'h0107_0000, mk(6,  6'h00, 16'h0000, 0, 2, 0, 0, 0, 1, 7,  1, 1), 1);
    send(32'h0001_1000, mk(7,  6'h00, 16'h1000, 0, 0, 0, 0, 0, 0, 0,  0, 0), 1);
    send(32'h0120_0000, mk(8,  6'h00, 16'h0000, 0, 0, 0, 0, 0, 0, 8,  1, 0), 1);
    send(32'hAC62_0000, mk(9,  6'h2B, 16'h0000, 1, 0, 0, 0, 0, 0, 0,  1, 0), 1);
    send(32'h0143_1800, mk(10, 6'h00, 16'h1800, 0, 0, 0, 1, 1, 0, 9,  1, 0), 1);
    send(32'h0160_0000, mk(11, 6'h00, 16'h0000, 0, 0, 0, 0, 0, 0, 3,  0, 0), 1);
    send(32'h0160_0000, mk(12, 6'h00, 16'h0000, 0, 0, 0, 0, 0, 0, 10, 1, 0), 1);
    send(32'h018B_5800, mk(13, 6'h00, 16'h5800, 0, 1, 1, 0, 0, 0, 11, 1, 0), 1);
    send(32'h8D8C_0000, mk(14, 6'h23, 16'h0000, 1, 1, 0, 0, 0, 0, 11, 1, 0), 1);
    send(32'h8DA0_0000, mk(15, 6'h23, 16'h0000, 1, 0, 0, 1, 0, 0, 12, 1, 0), 1);
    send(32'h35C0_6800, mk(16, 6'h0D, 16'h6800, 1, 0, 0, 1, 0, 1, 12, 1, 0), 1);
    idle(4);
    check("scoreboard_drained", sb_q.size(), 0);

    // Reset asserted while decode is stalled on a load-use.
    mon_en = 1'b0;
    send(32'h8CE0_0000, none, 0);
    send(32'h0107_0000, none, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_reset_stall", stall, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("midstall_reset_outputs", {op_dec, imm, imm_sel, mux_sel_A, mux_sel_B, mem_en_ex,
                                     mem_rw_ex, mem_mux_sel_dm, RW_dm, wb_en_dm, stall}, 0);
    check("midstall_reset_in_ready", in_ready, 1'b1);
    reset = 1'b1;
    idle(2);
    mon_en = 1'b1;

    // Three forwardable stages, loads forwardable only from the last one.
    @(posedge clk); #1;
    ins3 = 32'h8CE0_0000;
    in_valid3 = 1'b1;
    @(posedge clk); #1;
    check("s3_load_in_ready", in_ready3, 1'b1);
    ins3 = 32'h0107_0000;
    @(posedge clk); #1;
    in_valid3 = 1'b0;
    n = 0;
    while (!in_ready3 && n < 10) begin
      n++;
      @(posedge clk); #1;
    end
    check("s3_stall_cycles", n, 2);
    check("s3_mux_sel_A", mux_sel_A3, 2'd3);
    check("s3_mux_sel_B", mux_sel_B3, 2'd0);
    check("s3_mem_mux_sel_dm", mem_mux_sel_dm3, 1'b1);
    check("s3_RW_dm", RW_dm3, 5'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
